keypad_scanner: RTL
===================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 27000, clock cycles each column is held active before the row sample.
REQ-002 Parameter DEBOUNCE_CYCLES, default 270000, consecutive stable cycles required to accept a press or a release.
REQ-003 Port clk  input  1  system clock, all logic rising-edge.
REQ-004 Port rst  input  1  asynchronous, active-low reset.
REQ-005 Port filas  input  4  keypad row lines, active-low, asynchronous to clk.
REQ-006 Port columnas  output  4  column drive, one-hot-low.
REQ-007 Port key_code  output  4  code of the last accepted key.
REQ-008 Port key_valid  output  1  one-cycle pulse per accepted press.
REQ-009 Port key_held  output  1  high while the accepted key remains pressed.

Function
REQ-010 filas shall pass through a 2-flop synchronizer; all decisions shall use the synchronized value (rows_s).
REQ-011 FSM states shall be SCAN, DEBOUNCE, HELD, RELEASE.
REQ-012 SCAN: columnas shall rotate 1110 -> 1101 -> 1011 -> 0111 -> 1110, each held SCAN_DIV cycles; rows_s shall be sampled on the last cycle of each period.
REQ-013 SCAN: if the sample has any row low, the FSM shall latch the column index and the lowest-index low row, freeze columnas, and enter DEBOUNCE; otherwise it shall advance the column.
REQ-014 DEBOUNCE: a counter shall increment while rows_s equals the latched pattern; any mismatch shall return to SCAN, with the column advanced and the counter cleared.
REQ-015 DEBOUNCE: when the counter reaches DEBOUNCE_CYCLES-1, the block shall update key_code, pulse key_valid for exactly one cycle, and enter HELD.
REQ-016 Key map (row r, column c) -> code: r0: 1,2,3,A; r1: 4,5,6,B; r2: 7,8,9,C; r3: *=E, 0=0, #=F, D.
REQ-017 HELD: key_held shall be 1 and columnas frozen; when the latched row reads high, the FSM shall enter RELEASE with the counter cleared.
REQ-018 RELEASE: the counter shall increment while rows_s is all-high; any low row shall return to HELD; at DEBOUNCE_CYCLES-1 the FSM shall enter SCAN with the column advanced, and key_held shall drop.
REQ-019 A long press shall produce exactly one key_valid; no auto-repeat.
REQ-020 With multiple keys pressed, only the first accepted key shall be reported; further rows shall be ignored until full release.
REQ-021 key_code shall hold its value between presses; key_valid shall never be asserted for two consecutive cycles.
REQ-022 Counters shall be sized $clog2(max(SCAN_DIV, DEBOUNCE_CYCLES))+1 bits and shall saturate, never wrap.
REQ-023 Latency from a filas edge to key_valid shall be at most 2 + SCAN_DIV*4 + DEBOUNCE_CYCLES cycles.

Reset
REQ-024 On rst low, immediately: columnas=1110, key_code=0, key_valid=0, key_held=0, state=SCAN, counters and synchronizer flops cleared to idle (rows all-high).
REQ-025 Reset asserted mid-press shall abort without a pulse; after release of reset a still-pressed key shall be rescanned and reported once.

Verification (SCAN_DIV=4, DEBOUNCE_CYCLES=8; bench models a 4x4 matrix that pulls row r low when column c is low and key (r,c) is pressed)
REQ-026 Press "5" (r1,c1) for 40 cycles -> one key_valid with key_code=5, key_held=1 until release plus 8 stable cycles.
REQ-027 Press "#" then "*" sequentially -> key_code=F, then E, two pulses total.
REQ-028 Bounce on "7": 3 cycles low, 2 high, then stable low -> no pulse during the bounce, exactly one pulse with code 7 after 8 stable cycles.
REQ-029 Hold "A" for 200 cycles while also pressing "3" -> a single pulse with code A; "3" is not reported until "A" is released and rescanned.
REQ-030 Assert rst during HELD of "9" -> all outputs at reset values immediately; after deassertion with "9" still held -> exactly one pulse with code 9.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates a low column drive, debounces presses and
// releases on synchronized row lines, and reports one code pulse per key press.
module keypad_scanner #(
  parameter int SCAN_DIV        = 27000,
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] filas,
  output logic [3:0] columnas,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int MAX_DIV = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int CW      = $clog2(MAX_DIV) + 1;

  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t        state_q,     state_d;
  logic [3:0]    sync_meta_q, sync_meta_d;
  logic [3:0]    rows_s_q,    rows_s_d;
  logic [CW-1:0] cnt_q,       cnt_d;
  logic [1:0]    col_idx_q,   col_idx_d;
  logic [1:0]    row_idx_q,   row_idx_d;
  logic [3:0]    pattern_q,   pattern_d;
  logic [3:0]    columnas_q,  columnas_d;
  logic [3:0]    key_code_q,  key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_held_q,  key_held_d;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (v == CNT_MAX) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(CW-1){1'b0}}, 1'b1};
    end
  endfunction

  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    col_drive = ~(4'b0001 << idx);
  endfunction

  // Lowest-index low row wins when several rows are pulled down together.
  function automatic logic [1:0] low_row(input logic [3:0] rows);
    if (!rows[0]) begin
      low_row = 2'd0;
    end else if (!rows[1]) begin
      low_row = 2'd1;
    end else if (!rows[2]) begin
      low_row = 2'd2;
    end else begin
      low_row = 2'd3;
    end
  endfunction

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'b00_00: key_map = 4'h1;
      4'b00_01: key_map = 4'h2;
      4'b00_10: key_map = 4'h3;
      4'b00_11: key_map = 4'hA;
      4'b01_00: key_map = 4'h4;
      4'b01_01: key_map = 4'h5;
      4'b01_10: key_map = 4'h6;
      4'b01_11: key_map = 4'hB;
      4'b10_00: key_map = 4'h7;
      4'b10_01: key_map = 4'h8;
      4'b10_10: key_map = 4'h9;
      4'b10_11: key_map = 4'hC;
      4'b11_00: key_map = 4'hE;
      4'b11_01: key_map = 4'h0;
      4'b11_10: key_map = 4'hF;
      4'b11_11: key_map = 4'hD;
      default:  key_map = 4'h0;
    endcase
  endfunction

  // Next-state logic for the synchronizer, scan/debounce FSM and outputs.
  always_comb begin
    state_d     = state_q;
    sync_meta_d = filas;
    rows_s_d    = sync_meta_q;
    cnt_d       = cnt_q;
    col_idx_d   = col_idx_q;
    row_idx_d   = row_idx_q;
    pattern_d   = pattern_q;
    columnas_d  = columnas_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;

    case (state_q)
      SCAN: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = CNT_ZERO;
          if (rows_s_q != 4'hF) begin
            pattern_d = rows_s_q;
            row_idx_d = low_row(rows_s_q);
            state_d   = DEBOUNCE;
          end else begin
            col_idx_d  = col_idx_q + 2'd1;
            columnas_d = col_drive(col_idx_q + 2'd1);
          end
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end

      DEBOUNCE: begin
        if (rows_s_q == pattern_q) begin
          if (cnt_q == DB_LAST) begin
            cnt_d       = CNT_ZERO;
            key_code_d  = key_map(row_idx_q, col_idx_q);
            key_valid_d = 1'b1;
            key_held_d  = 1'b1;
            state_d     = HELD;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end else begin
          cnt_d      = CNT_ZERO;
          col_idx_d  = col_idx_q + 2'd1;
          columnas_d = col_drive(col_idx_q + 2'd1);
          state_d    = SCAN;
        end
      end

      HELD: begin
        if (rows_s_q[row_idx_q]) begin
          cnt_d   = CNT_ZERO;
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q;
        end
      end

      // Another row going low here keeps the key held, so no second key is
      // reported until every row has been idle for the full debounce time.
      RELEASE: begin
        if (rows_s_q == 4'hF) begin
          if (cnt_q == DB_LAST) begin
            cnt_d      = CNT_ZERO;
            key_held_d = 1'b0;
            col_idx_d  = col_idx_q + 2'd1;
            columnas_d = col_drive(col_idx_q + 2'd1);
            state_d    = SCAN;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end else begin
          cnt_d   = CNT_ZERO;
          state_d = HELD;
        end
      end

      default: begin
        cnt_d      = CNT_ZERO;
        col_idx_d  = 2'd0;
        columnas_d = 4'b1110;
        key_held_d = 1'b0;
        state_d    = SCAN;
      end
    endcase
  end

  // State and output registers; synchronizer idles at all-high rows.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= SCAN;
      sync_meta_q <= 4'hF;
      rows_s_q    <= 4'hF;
      cnt_q       <= CNT_ZERO;
      col_idx_q   <= 2'd0;
      row_idx_q   <= 2'd0;
      pattern_q   <= 4'hF;
      columnas_q  <= 4'b1110;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_meta_q <= sync_meta_d;
      rows_s_q    <= rows_s_d;
      cnt_q       <= cnt_d;
      col_idx_q   <= col_idx_d;
      row_idx_q   <= row_idx_d;
      pattern_q   <= pattern_d;
      columnas_q  <= columnas_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign columnas  = columnas_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule
